// File: rtl/seg_bcd_formatter_pkg.sv
// Shared types and constants for the seven-segment value formatter.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seg_state_e;

    localparam logic        MODE_HEX   = 1'b0;
    localparam logic        MODE_DEC   = 1'b1;
    localparam int unsigned SEG_DIGITS = 8;

endpackage

// File: rtl/seg_bcd_formatter_if.sv
// Request/result bundle between the debug-value mux and the formatter.
interface seg_bcd_formatter_if #(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned DIGITS = 8
);
    logic [IN_W-1:0]     value;
    logic                mode;
    logic                req;
    logic                ready;
    logic [4*DIGITS-1:0] display_data;
    logic                valid;
    logic                ovf;

    modport master (
        output value, mode, req,
        input  ready, display_data, valid, ovf
    );

    modport slave (
        input  value, mode, req,
        output ready, display_data, valid, ovf
    );
endinterface

// File: rtl/seg_bcd_formatter_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end
endmodule

// File: rtl/seg_bcd_formatter.sv
// Hex passthrough / sequential binary-to-BCD formatter feeding the segment scanner.
module seg_bcd_formatter
    import seg_pkg::*;
#(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned DIGITS = SEG_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_bcd_formatter_if.slave  bus
);
    localparam int unsigned ACC_W = 4 * (DIGITS + 2);
    localparam int unsigned CNT_W = $clog2(IN_W + 1);
    localparam int unsigned DSP_W = 4 * DIGITS;

    seg_state_e         state_q, state_d;
    logic [IN_W-1:0]    shreg_q, shreg_d;
    logic               mode_q, mode_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DSP_W-1:0]   disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic [ACC_W-1:0]   acc_adj;

    for (genvar g = 0; g < int'(DIGITS + 2); g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[4*g +: 4]),
            .digit_o (acc_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            mode_q  <= MODE_HEX;
            acc_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    shreg_d = bus.value;
                    mode_d  = bus.mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (bus.mode == MODE_DEC) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                {acc_d, shreg_d} = {acc_adj, shreg_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Hex mode never shifts, so the shift register still holds the raw value.
                if (mode_q == MODE_HEX) begin
                    disp_d = shreg_q[DSP_W-1:0];
                    ovf_d  = 1'b0;
                end else begin
                    disp_d = acc_q[DSP_W-1:0];
                    ovf_d  = |acc_q[ACC_W-1:DSP_W];
                end
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.ready        = (state_q == ST_IDLE);
    assign bus.display_data = disp_q;
    assign bus.valid        = valid_q;
    assign bus.ovf          = ovf_q;
endmodule

// File: tb/tb_seg_bcd_formatter.sv
// Randomised and directed checks of seg_bcd_formatter against a cycle-level arithmetic model.
module tb_seg_bcd_formatter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    seg_bcd_formatter_if #(.IN_W(32), .DIGITS(8)) bus ();

    seg_bcd_formatter #(.IN_W(32), .DIGITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Model: result of an accepted request, and cycles left until it is committed.
    logic        started = 1'b0;
    int unsigned m_busy = 0;
    logic [31:0] m_disp = '0, p_disp = '0;
    logic        m_ovf = 1'b0, p_ovf = 1'b0, m_valid = 1'b0;

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_n) begin
            m_disp = '0; m_ovf = 1'b0; m_valid = 1'b0; m_busy = 0;
        end else begin
            m_valid = 1'b0;
            if (m_busy != 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_disp = p_disp; m_ovf = p_ovf; m_valid = 1'b1;
                end
            end else if (bus.req) begin
                if (bus.mode) begin
                    p_disp = to_bcd(bus.value % 100000000);
                    p_ovf  = (bus.value >= 100000000);
                    m_busy = 33;
                end else begin
                    p_disp = bus.value;
                    p_ovf  = 1'b0;
                    m_busy = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ready", {31'd0, bus.ready}, {31'd0, m_busy == 0});
            chk("valid", {31'd0, bus.valid}, {31'd0, m_valid});
            chk("display_data", bus.display_data, m_disp);
            chk("ovf", {31'd0, bus.ovf}, {31'd0, m_ovf});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int unsigned n;
        n = 0;
        while (!bus.ready && n < 100) begin
            step();
            n++;
        end
        if (!bus.ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one request and return the accept-to-valid latency in cycles.
    task automatic issue(input logic m, input logic [31:0] v, output int unsigned lat);
        wait_ready();
        bus.req = 1'b1; bus.mode = m; bus.value = v;
        step();
        bus.req = 1'b0; bus.mode = ~m; bus.value = $urandom;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!bus.valid && lat < 100);
    endtask

    task automatic op(input string name, input logic m, input logic [31:0] v,
                      input logic [31:0] exp_d, input logic exp_o);
        int unsigned lat;
        issue(m, v, lat);
        chk({name, "_lat"}, lat, m ? 32'd33 : 32'd1);
        chk({name, "_data"}, bus.display_data, exp_d);
        chk({name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_o});
    endtask

    function automatic logic [31:0] pick_value();
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return $urandom_range(0, 999);
            2: return $urandom_range(99999990, 100000010);
            3: return 32'hFFFF_FFFF;
            4: return $urandom_range(0, 99999999);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int unsigned lat, rdy_hi, pulses;
        bus.req = 1'b0; bus.mode = 1'b0; bus.value = '0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_data", bus.display_data, 32'h0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);

        op("hex_dead", 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        step();
        chk("hex_single_valid", {31'd0, bus.valid}, 32'd0);
        op("dec_1234", 1'b1, 32'd12345678, 32'h12345678, 1'b0);
        op("dec_9999", 1'b1, 32'd99999999, 32'h99999999, 1'b0);
        op("dec_zero", 1'b1, 32'd0, 32'h00000000, 1'b0);
        op("dec_1e8", 1'b1, 32'd100000000, 32'h00000000, 1'b1);
        op("dec_max", 1'b1, 32'hFFFFFFFF, 32'h94967295, 1'b1);

        // Busy protection: a second request mid-conversion is dropped.
        wait_ready();
        bus.req = 1'b1; bus.mode = 1'b1; bus.value = 32'd12345678;
        step();
        bus.req = 1'b0;
        rdy_hi = 0; pulses = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 10) begin bus.req = 1'b1; bus.value = 32'd7; end
            else bus.req = 1'b0;
            if (c < 33 && bus.ready) rdy_hi++;
            step();
            if (bus.valid) pulses++;
            if (c == 33) chk("busy_data", bus.display_data, 32'h12345678);
        end
        chk("busy_ready_low", rdy_hi, 32'd0);
        chk("busy_pulses", pulses, 32'd1);

        // Reset mid-conversion abandons the result.
        wait_ready();
        bus.req = 1'b1; bus.mode = 1'b1; bus.value = 32'd87654321;
        step();
        bus.req = 1'b0;
        repeat (14) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.valid) pulses++;
        end
        chk("rstmid_data", bus.display_data, 32'h0);
        chk("rstmid_pulses", pulses, 32'd0);
        op("hex_abcd", 1'b0, 32'h0000ABCD, 32'h0000ABCD, 1'b0);

        // Random traffic: requests every cycle regardless of ready, rare resets.
        for (int c = 0; c < 8000; c++) begin
            bus.req   = ($urandom_range(0, 3) != 0);
            bus.mode  = $urandom_range(0, 1);
            bus.value = pick_value();
            rst_n     = ($urandom_range(0, 999) != 0);
            step();
        end
        rst_n = 1'b1;
        bus.req = 1'b0;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_bcd_formatter.md
# seg_bcd_formatter

Formats a 32-bit binary value into the 32-bit nibble word consumed by the 8-digit seven-segment scan driver. It supports raw hex passthrough and unsigned decimal conversion. Decimal conversion is a sequential shift-and-add-3 (double dabble) engine that produces 8 BCD digits plus an overflow flag. It sits in the PDU between the debug-value mux and the segment scanner. Its registered `display_data` output holds stable between updates, so the scanner never shows a partial result.

## Interface
- `IN_W`, 32: input value width; conversion length in cycles.
- `DIGITS`, 8: displayed digits; `display_data` width is 4*DIGITS.
- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `value` input IN_W: binary value to format; sampled only on an accepted request.
- `mode` input 1: 0 = hex passthrough, 1 = unsigned decimal; sampled with `value`.
- `req` input 1: conversion request; accepted when `req && ready`.
- `ready` output 1: high exactly while FSM is in IDLE.
- `display_data` output 4*DIGITS: nibble word to the scanner; digit 0 in bits [3:0].
- `valid` output 1: one-cycle pulse; high in the cycle after `display_data` updates.
- `ovf` output 1: decimal value exceeded 10^DIGITS−1; updated together with `display_data`.

## Operation
- Reset (`rst_n`=0 at a clk edge):
  - FSM → IDLE, `display_data`=0, `ovf`=0, `valid`=0.
  - `ready`=1 from the first cycle after reset.
  - Reset mid-conversion abandons the conversion; `display_data` is cleared, not committed.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, on accept:
  - Latch `value` into a shift register and `mode`.
  - Clear the BCD accumulator (4*(DIGITS+2) bits = 40) and the 6-bit shift counter.
  - Next state is SHIFT if `mode`=1, DONE if `mode`=0.
- SHIFT, each cycle:
  - Every accumulator digit ≥5 gets +3.
  - Then shift {accumulator, shift register} left by 1; the MSB of the shift register enters accumulator bit 0.
  - Counter increments; after IN_W shifts (counter == IN_W−1 at the edge) go to DONE.
- DONE, one cycle; at its closing edge:
  - Hex: `display_data` ← latched value[4*DIGITS-1:0], `ovf` ← 0.
  - Decimal: `display_data` ← accumulator low DIGITS digits, `ovf` ← OR of accumulator upper 2 digits.
  - `valid` ← 1 for one cycle; FSM → IDLE.
- `req` while not ready is ignored, not queued. `value`/`mode` changes after accept have no effect.
- No leading-zero blanking; all digits are shown.
- Accumulator arithmetic: add-3 per 4-bit digit, no carry between digits. Digits never exceed 9 after a shift.

## Timing
- Accept at edge E0.
- Hex: `display_data` updates at E1; `valid` high in the E1–E2 cycle; `ready` high again after E1. Total latency 1 cycle.
- Decimal: shifts at E1..E32; DONE commit at E33; `valid` high in the E33–E34 cycle. Total latency IN_W+1 = 33 cycles.
- Back-to-back: `req` held high is re-accepted at the edge after the commit edge. Minimum issue interval is 2 cycles (hex) and 34 cycles (decimal).
- `display_data` changes only at commit edges or reset; it is glitch-free to the scanner.

## Structure
- Shared package `seg_pkg` holds:
  - state encoding constants `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_DONE`=2'd2;
  - `MODE_HEX`=1'b0, `MODE_DEC`=1'b1;
  - default `SEG_DIGITS`=8.
- Sub-module `bcd_digit_adj` is combinational: 4-bit in, output in+3 if in≥5 else in. It is instantiated DIGITS+2 times by generate.
- FSM, counter, and output registers live in `seg_bcd_formatter`.

## Test plan
- Reset then idle: `display_data`=32'h00000000, `ovf`=0, `valid`=0, `ready`=1.
- Hex: mode=0, value=32'hDEADBEEF → at E1, `display_data`=32'hDEADBEEF, `ovf`=0, single `valid` pulse.
- Decimal in range:
  - 12345678 → 32'h12345678, `ovf`=0, `valid` exactly 33 cycles after accept.
  - 99999999 → 32'h99999999, `ovf`=0.
  - 0 → 32'h00000000.
- Decimal overflow:
  - 100000000 → 32'h00000000, `ovf`=1.
  - 32'hFFFFFFFF (4294967295) → 32'h94967295, `ovf`=1.
- Busy protection: accept 12345678 decimal, then pulse `req` with value=7 at cycle 10 → ignored; result is 32'h12345678 with a single `valid`; `ready` was 0 during cycles 1–33.
- Reset mid-operation: `rst_n`=0 at cycle 15 of a conversion → `display_data`=0, no `valid`. A new hex request 32'h0000ABCD then completes normally.
